// File: rtl/fpu_share_pkg.sv
// fpu_share_pkg
// Types and constants shared by the FPU sharing controller and its
// round-robin arbiter: FSM state encoding, lane identifiers and the data
// and destination-register widths used on both issue lanes.
package fpu_share_pkg;

   localparam int DATA_W = 32;
   localparam int RT_W   = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } fsm_state_e;

   typedef enum logic {
      LANE_U = 1'b0,
      LANE_L = 1'b1
   } lane_e;

endpackage

// File: rtl/fpu_share_ctrl_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   en    in   grants allowed this cycle
//   req   in   [0] = upper lane, [1] = lower lane
//   prio  in   lane that wins when both request (pointer register lives
//              in the parent, which advances it on every grant)
//   gnt   out  one-hot grant, all zero when en=0 or no request
module rr_arb2
   import fpu_share_pkg::*;
(
   input  logic       en,
   input  logic [1:0] req,
   input  lane_e      prio,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) begin
            gnt = (prio == LANE_L) ? 2'b10 : 2'b01;
         end else begin
            gnt = req;
         end
      end
   end

endmodule

// File: rtl/fpu_share_ctrl.sv
// fpu_share_ctrl
// Shares one non-pipelined multi-cycle FPU unit between the upper (u) and
// lower (l) issue lanes. One op is accepted at a time, sequenced through
// START/WAIT/RESP, and its result is returned to the lane that issued it.
//
// Handshake: a lane raises <lane>_req with operands and rt stable; the
// request is accepted in the cycle <lane>_gnt is high (combinational, only
// in IDLE with interlock low). Operands are captured at the end of that
// cycle and the lane may drop or change its request from the next cycle.
// The unit is started by a one-cycle unit_start pulse and answers with a
// one-cycle unit_done; the result is returned as a one-cycle
// <lane>_res_valid pulse with rt_flag as writeback enable.
//
// Ports:
//   clk, rstn                 clock, async active-low reset
//   interlock                 blocks new grants (does not stall an op)
//   u_/l_req, _srca, _srcb,
//   _rt, _kill                lane request, operands, destination, squash
//   u_/l_gnt                  request accepted this cycle
//   unit_start, unit_srca/b   start pulse and latched operands to the unit
//   unit_done, unit_tdata     result strobe and data from the unit
//   u_/l_res_valid, _tdata,
//   _rt_out, _rt_flag         result pulse returned to the issuing lane
//   busy                      FSM not in IDLE
//   err                       sticky: an op was abandoned on timeout
//   state_dbg                 current FSM state
module fpu_share_ctrl
   import fpu_share_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              interlock,
   input  logic              u_req,
   input  logic [DATA_W-1:0] u_srca,
   input  logic [DATA_W-1:0] u_srcb,
   input  logic [RT_W-1:0]   u_rt,
   input  logic              u_kill,
   input  logic              l_req,
   input  logic [DATA_W-1:0] l_srca,
   input  logic [DATA_W-1:0] l_srcb,
   input  logic [RT_W-1:0]   l_rt,
   input  logic              l_kill,
   output logic              u_gnt,
   output logic              l_gnt,
   output logic              unit_start,
   output logic [DATA_W-1:0] unit_srca,
   output logic [DATA_W-1:0] unit_srcb,
   input  logic              unit_done,
   input  logic [DATA_W-1:0] unit_tdata,
   output logic              u_res_valid,
   output logic [DATA_W-1:0] u_tdata,
   output logic [RT_W-1:0]   u_rt_out,
   output logic              u_rt_flag,
   output logic              l_res_valid,
   output logic [DATA_W-1:0] l_tdata,
   output logic [RT_W-1:0]   l_rt_out,
   output logic              l_rt_flag,
   output logic              busy,
   output logic              err,
   output fsm_state_e        state_dbg
);

   localparam int CNT_W = $clog2(TIMEOUT);
   // cnt_q holds the number of WAIT cycles already completed, so the cycle
   // in progress is number cnt_q+1. When that is TIMEOUT-1 with no done,
   // the op is abandoned; the FSM is back in IDLE TIMEOUT cycles after START.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

   fsm_state_e        state_q, state_d;
   lane_e             prio_q, prio_d;
   lane_e             lane_q, lane_d;
   logic [DATA_W-1:0] srca_q, srca_d;
   logic [DATA_W-1:0] srcb_q, srcb_d;
   logic [RT_W-1:0]   rt_q, rt_d;
   logic              kill_q, kill_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic [1:0] arb_gnt;
   logic       arb_en;
   logic       lane_kill;
   logic       resp_u, resp_l;

   // Grants are only offered in IDLE, and are suppressed while in reset.
   assign arb_en = rstn && !interlock && (state_q == IDLE);

   rr_arb2 u_arb (
      .en   (arb_en),
      .req  ({l_req, u_req}),
      .prio (prio_q),
      .gnt  (arb_gnt)
   );

   assign u_gnt = arb_gnt[0];
   assign l_gnt = arb_gnt[1];

   // Kill of the lane that owns the current op; the other lane's kill is
   // irrelevant to it.
   assign lane_kill = (lane_q == LANE_U) ? u_kill : l_kill;

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      lane_d  = lane_q;
      srca_d  = srca_q;
      srcb_d  = srcb_q;
      rt_d    = rt_q;
      kill_d  = kill_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (arb_gnt != 2'b00) begin
               lane_d  = arb_gnt[1] ? LANE_L : LANE_U;
               prio_d  = arb_gnt[1] ? LANE_U : LANE_L;
               srca_d  = arb_gnt[1] ? l_srca : u_srca;
               srcb_d  = arb_gnt[1] ? l_srcb : u_srcb;
               rt_d    = arb_gnt[1] ? l_rt   : u_rt;
               // A kill in the grant cycle already counts against the op.
               kill_d  = arb_gnt[1] ? l_kill : u_kill;
               state_d = START;
            end
         end
         START: begin
            cnt_d   = '0;
            kill_d  = kill_q | lane_kill;
            state_d = WAIT;
         end
         WAIT: begin
            kill_d = kill_q | lane_kill;
            // done wins over timeout in the last allowed WAIT cycle.
            if (unit_done) begin
               res_d   = unit_tdata;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         prio_q  <= LANE_U;
         lane_q  <= LANE_U;
         srca_q  <= '0;
         srcb_q  <= '0;
         rt_q    <= '0;
         kill_q  <= 1'b0;
         res_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         lane_q  <= lane_d;
         srca_q  <= srca_d;
         srcb_q  <= srcb_d;
         rt_q    <= rt_d;
         kill_q  <= kill_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign unit_start = (state_q == START);
   assign unit_srca  = srca_q;
   assign unit_srcb  = srcb_q;

   assign resp_u = (state_q == RESP) && (lane_q == LANE_U);
   assign resp_l = (state_q == RESP) && (lane_q == LANE_L);

   // A kill arriving in the RESP cycle itself still blocks the write.
   assign u_res_valid = resp_u;
   assign u_tdata     = resp_u ? res_q : '0;
   assign u_rt_out    = resp_u ? rt_q  : '0;
   assign u_rt_flag   = resp_u && !(kill_q || u_kill);

   assign l_res_valid = resp_l;
   assign l_tdata     = resp_l ? res_q : '0;
   assign l_rt_out    = resp_l ? rt_q  : '0;
   assign l_rt_flag   = resp_l && !(kill_q || l_kill);

   assign busy      = (state_q != IDLE);
   assign err       = err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_fpu_share_ctrl.sv
// tb_fpu_share_ctrl
// Self-checking bench for fpu_share_ctrl (TIMEOUT=8) with a stub FPU unit
// that answers D cycles after a start pulse.
module tb_fpu_share_ctrl;

   localparam int TO = 8;

   logic        clk, rstn, interlock;
   logic        u_req, l_req, u_kill, l_kill;
   logic [31:0] u_srca, u_srcb, l_srca, l_srcb;
   logic [4:0]  u_rt, l_rt;
   logic        u_gnt, l_gnt, unit_start, unit_done;
   logic [31:0] unit_srca, unit_srcb, unit_tdata;
   logic        u_res_valid, l_res_valid, u_rt_flag, l_rt_flag;
   logic [31:0] u_tdata, l_tdata;
   logic [4:0]  u_rt_out, l_rt_out;
   logic        busy, err;
   logic [1:0]  state_dbg;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model: lane holding tie priority (0=u, 1=l) and sticky err
   int mdl_prio = 0;
   bit mdl_err = 0;

   // operands for the next op
   logic [31:0] op_ua, op_ub, op_la, op_lb, op_res;
   logic [4:0]  op_urt, op_lrt;

   // stub unit control
   int          stub_delay = 0;
   logic [31:0] stub_data = 0;
   int          stray_cnt = 0;

   fpu_share_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn), .interlock(interlock),
      .u_req(u_req), .u_srca(u_srca), .u_srcb(u_srcb), .u_rt(u_rt), .u_kill(u_kill),
      .l_req(l_req), .l_srca(l_srca), .l_srcb(l_srcb), .l_rt(l_rt), .l_kill(l_kill),
      .u_gnt(u_gnt), .l_gnt(l_gnt),
      .unit_start(unit_start), .unit_srca(unit_srca), .unit_srcb(unit_srcb),
      .unit_done(unit_done), .unit_tdata(unit_tdata),
      .u_res_valid(u_res_valid), .u_tdata(u_tdata), .u_rt_out(u_rt_out), .u_rt_flag(u_rt_flag),
      .l_res_valid(l_res_valid), .l_tdata(l_tdata), .l_rt_out(l_rt_out), .l_rt_flag(l_rt_flag),
      .busy(busy), .err(err), .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- stub unit ----------------
   // Sees unit_start in cycle S and pulses done in cycle S+D (D=0: never).
   // stray_cnt bumps produce an unsolicited done pulse in that cycle.
   initial begin
      int countdown;
      int stray_seen;
      countdown = 0;
      stray_seen = 0;
      unit_done = 0;
      unit_tdata = 0;
      forever begin
         @(negedge clk);
         if (unit_start === 1'b1) countdown = stub_delay;
         @(posedge clk);
         #2;
         unit_done = 0;
         unit_tdata = 0;
         if (countdown == 1 || stray_cnt != stray_seen) begin
            unit_done = 1;
            unit_tdata = stub_data;
         end
         stray_seen = stray_cnt;
         if (countdown > 0) countdown--;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ops();
      op_ua = $urandom; op_ub = $urandom; op_la = $urandom; op_lb = $urandom;
      op_urt = 5'($urandom_range(0, 31)); op_lrt = 5'($urandom_range(0, 31));
      op_res = $urandom;
   endtask

   // Issues one op starting in the current cycle (entered at posedge+1 of
   // an IDLE cycle) and checks every cycle until the FSM is due back in
   // IDLE; returns at posedge+1 of that IDLE cycle.
   // d: unit latency (0 = never answers); kill_at: cycle offset from the
   // grant cycle at which kill_lane's kill pulses (-1 = none).
   task automatic drive_op(input bit ur, input bit lr, input int d, input int kill_at,
                           input int kill_lane, input bit noise);
      int lane, last_c;
      bit timed_out, killed, resp;
      logic [31:0] ea, eb, obs_td;
      logic [4:0]  ert, obs_rt;
      logic        obs_flag;
      logic [37:0] oth;
      lane = (ur && lr) ? mdl_prio : (ur ? 0 : 1);
      mdl_prio = 1 - lane;
      timed_out = (d == 0) || (d > TO - 1);
      last_c = timed_out ? TO : d + 2;
      killed = !timed_out && kill_lane == lane && kill_at >= 0 && kill_at <= d + 2;
      ea  = (lane == 0) ? op_ua : op_la;
      eb  = (lane == 0) ? op_ub : op_lb;
      ert = (lane == 0) ? op_urt : op_lrt;
      stub_delay = d;
      stub_data = op_res;
      u_srca = op_ua; u_srcb = op_ub; u_rt = op_urt;
      l_srca = op_la; l_srcb = op_lb; l_rt = op_lrt;
      for (int c = 0; c <= last_c; c++) begin
         u_req = (c == 0) ? ur : (ur && lane != 0);
         l_req = (c == 0) ? lr : (lr && lane != 1);
         u_kill = (c == kill_at) && kill_lane == 0;
         l_kill = (c == kill_at) && kill_lane == 1;
         interlock = noise && c > 0 && ($urandom_range(0, 1) == 1);
         if (c == 1) begin
            u_srca = $urandom; u_srcb = $urandom; l_srca = $urandom; l_srcb = $urandom;
            u_rt = 5'($urandom_range(0, 31)); l_rt = 5'($urandom_range(0, 31));
         end
         resp = !timed_out && c == d + 2;
         @(negedge clk);
         n_cmp++;
         if (u_gnt !== (c == 0 && lane == 0)) begin
            n_fail++; $display("FAIL u_gnt c%0d: got %b want %b", c, u_gnt, (c == 0 && lane == 0));
         end
         n_cmp++;
         if (l_gnt !== (c == 0 && lane == 1)) begin
            n_fail++; $display("FAIL l_gnt c%0d: got %b want %b", c, l_gnt, (c == 0 && lane == 1));
         end
         n_cmp++;
         if (busy !== (c != 0)) begin
            n_fail++; $display("FAIL busy c%0d: got %b want %b", c, busy, (c != 0));
         end
         n_cmp++;
         if (unit_start !== (c == 1)) begin
            n_fail++; $display("FAIL unit_start c%0d: got %b want %b", c, unit_start, (c == 1));
         end
         if (c == 1) begin
            n_cmp++;
            if (unit_srca !== ea || unit_srcb !== eb) begin
               n_fail++; $display("FAIL operands: got %h/%h want %h/%h", unit_srca, unit_srcb, ea, eb);
            end
         end
         n_cmp++;
         if (u_res_valid !== (resp && lane == 0) || l_res_valid !== (resp && lane == 1)) begin
            n_fail++; $display("FAIL res_valid c%0d: got u%b l%b want u%b l%b", c, u_res_valid,
                               l_res_valid, (resp && lane == 0), (resp && lane == 1));
         end
         n_cmp++;
         if (err !== mdl_err) begin
            n_fail++; $display("FAIL err c%0d: got %b want %b", c, err, mdl_err);
         end
         if (resp) begin
            obs_td   = (lane == 0) ? u_tdata : l_tdata;
            obs_rt   = (lane == 0) ? u_rt_out : l_rt_out;
            obs_flag = (lane == 0) ? u_rt_flag : l_rt_flag;
            oth      = (lane == 0) ? {l_tdata, l_rt_out, l_rt_flag} : {u_tdata, u_rt_out, u_rt_flag};
            n_cmp++;
            if (obs_td !== op_res) begin
               n_fail++; $display("FAIL tdata lane%0d: got %h want %h", lane, obs_td, op_res);
            end
            n_cmp++;
            if (obs_rt !== ert) begin
               n_fail++; $display("FAIL rt_out lane%0d: got %0d want %0d", lane, obs_rt, ert);
            end
            n_cmp++;
            if (obs_flag !== !killed) begin
               n_fail++; $display("FAIL rt_flag lane%0d: got %b want %b", lane, obs_flag, !killed);
            end
            n_cmp++;
            if (oth !== '0) begin
               n_fail++; $display("FAIL other lane outputs: got %h want 0", oth);
            end
         end
         step();
      end
      u_req = 0; l_req = 0; u_kill = 0; l_kill = 0; interlock = 0;
      if (timed_out) mdl_err = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rstn = 0; interlock = 0; u_req = 1; l_req = 1; u_kill = 0; l_kill = 0;
      u_srca = $urandom; u_srcb = $urandom; l_srca = $urandom; l_srcb = $urandom;
      u_rt = 5'd3; l_rt = 5'd4;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({u_gnt, l_gnt, busy, err, unit_start, u_res_valid, l_res_valid} !== 7'b0) begin
            n_fail++; $display("FAIL reset ctrl: got %b want 0",
                               {u_gnt, l_gnt, busy, err, unit_start, u_res_valid, l_res_valid});
         end
         n_cmp++;
         if ({unit_srca, unit_srcb, u_tdata, l_tdata} !== '0) begin
            n_fail++; $display("FAIL reset data: got %h/%h want 0", unit_srca, unit_srcb);
         end
         step();
      end
      rstn = 1; u_req = 0; l_req = 0;
      mdl_prio = 0; mdl_err = 0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || state_dbg !== 2'd0) begin
         n_fail++; $display("FAIL post reset idle: got busy %b state %0d want 0/0", busy, state_dbg);
      end
      step();
   endtask

   task automatic test_single_u();
      rand_ops();
      op_ua = 32'h40800000; op_ub = 32'h40000000; op_urt = 5'd7; op_res = 32'h40000000;
      drive_op(1, 0, 5, -1, 0, 0);
   endtask

   task automatic test_contention();
      for (int i = 0; i < 3; i++) begin
         rand_ops();
         drive_op(1, 1, $urandom_range(1, TO - 1), -1, 0, 0);
      end
   endtask

   task automatic test_kill();
      rand_ops(); drive_op(0, 1, 5, 3, 1, 0);   // kill in WAIT
      rand_ops(); drive_op(1, 0, 4, -1, 0, 0);  // next op unaffected
      rand_ops(); drive_op(1, 0, 3, 0, 0, 0);   // kill in grant cycle
      rand_ops(); drive_op(0, 1, 2, 4, 1, 0);   // kill in RESP cycle
      rand_ops(); drive_op(0, 1, 3, 3, 0, 0);   // other lane's kill ignored
      rand_ops(); drive_op(1, 0, 1, 1, 0, 0);   // kill in START
   endtask

   task automatic test_interlock();
      rand_ops();
      interlock = 1; u_req = 1; u_srca = op_ua; u_srcb = op_ub; u_rt = op_urt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (u_gnt !== 1'b0 || l_gnt !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL interlock hold %0d: got gnt %b%b busy %b want 0", i, u_gnt, l_gnt, busy);
         end
         step();
      end
      drive_op(1, 0, 3, -1, 0, 0);
      rand_ops(); drive_op(0, 1, 4, -1, 0, 1);  // interlock toggling mid-op
   endtask

   task automatic test_timeout();
      rand_ops();
      drive_op(1, 0, 0, -1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) stray_cnt++;  // late done while IDLE
         @(negedge clk);
         n_cmp++;
         if (busy !== 1'b0 || err !== 1'b1 || u_res_valid !== 1'b0 || l_res_valid !== 1'b0) begin
            n_fail++; $display("FAIL after timeout %0d: got busy %b err %b rv %b%b want 0 1 00",
                               i, busy, err, u_res_valid, l_res_valid);
         end
         step();
      end
      rand_ops(); drive_op(0, 1, TO - 1, -1, 0, 0);  // done in last WAIT cycle
      rand_ops(); drive_op(1, 0, TO, -1, 0, 0);      // done one cycle too late
      rand_ops(); drive_op(1, 1, 1, -1, 0, 0);       // minimum latency
   endtask

   task automatic test_reset_mid_wait();
      rand_ops();
      stub_delay = 4; stub_data = op_res;
      u_req = 1; u_srca = op_ua; u_srcb = op_ub; u_rt = op_urt;
      @(negedge clk);
      n_cmp++;
      if (u_gnt !== (mdl_prio == 0 || 1)) begin
         n_fail++; $display("FAIL rst op grant: got %b want 1", u_gnt);
      end
      mdl_prio = 1;
      step(); u_req = 0;
      step();
      step(); rstn = 0; u_req = 1; l_req = 1;
      @(negedge clk);
      n_cmp++;
      if ({busy, u_gnt, l_gnt, unit_start, err, u_res_valid, l_res_valid} !== 7'b0) begin
         n_fail++; $display("FAIL mid-wait reset ctrl: got %b want 0",
                            {busy, u_gnt, l_gnt, unit_start, err, u_res_valid, l_res_valid});
      end
      n_cmp++;
      if (unit_srca !== 32'h0 || unit_srcb !== 32'h0) begin
         n_fail++; $display("FAIL mid-wait reset operands: got %h/%h want 0", unit_srca, unit_srcb);
      end
      mdl_prio = 0; mdl_err = 0;
      step(); rstn = 1; u_req = 0; l_req = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (busy !== 1'b0 || u_res_valid !== 1'b0 || l_res_valid !== 1'b0) begin
            n_fail++; $display("FAIL stale done %0d: got busy %b rv %b%b want 0", i, busy, u_res_valid, l_res_valid);
         end
         step();
      end
      rand_ops(); drive_op(1, 1, 2, -1, 0, 0);  // u must win after reset
   endtask

   task automatic test_random();
      bit ur, lr;
      for (int i = 0; i < 20; i++) begin
         rand_ops();
         ur = ($urandom_range(0, 1) == 1);
         lr = ur ? ($urandom_range(0, 1) == 1) : 1'b1;
         drive_op(ur, lr, $urandom_range(0, TO + 1), $urandom_range(0, 14) - 2,
                  $urandom_range(0, 1), 1);
      end
   endtask

   // ---------------- main ----------------
   initial begin
      test_reset();
      test_single_u();
      test_contention();
      test_kill();
      test_interlock();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
